pcie_lector: RTL

PCIE_LECTOR -- requirements
Module: pcie_lector

---
 rtl/pcie_lector.sv | 94 +++++++++
 1 files changed

// File: rtl/pcie_lector.sv
// pcie_lector: round-robin reader of the D0/D1 destination FIFOs with word capture, counters and state flags.
// Define PCIE_LECTOR_DEST_CHECK_EN to flag captured words whose bit 4 disagrees with their source FIFO.
module pcie_lector #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic             hold,
    input  logic             empty_D0,
    input  logic             empty_D1,
    input  logic [5:0]       data_out0,
    input  logic [5:0]       data_out1,
    output logic             pop_D0,
    output logic             pop_D1,
    output logic [5:0]       data_rx,
    output logic             valid_rx,
    output logic             src_rx,
    output logic [CNT_W-1:0] cnt_D0,
    output logic [CNT_W-1:0] cnt_D1,
    output logic             idle_rx,
    output logic             active_rx,
    output logic             error_rx
);
    typedef enum logic [1:0] {INIT, IDLE, ACTIVE, ERROR} state_t;

    state_t     state, state_nx;
    logic       rr, sel, req, pop_err, dest_err;
    logic [5:0] data_q;

    always_comb begin
        sel      = (!empty_D0 && !empty_D1) ? rr : empty_D0;
        req      = (state == IDLE || state == ACTIVE) && !hold && !init && !(empty_D0 && empty_D1);
        pop_D0   = req && !sel && !empty_D0;
        pop_D1   = req && sel && !empty_D1;
        // a pop aimed at an empty FIFO is suppressed above and reported here
        pop_err  = req && (sel ? empty_D1 : empty_D0);
        data_rx  = valid_rx ? (src_rx ? data_out1 : data_out0) : data_q;
`ifdef PCIE_LECTOR_DEST_CHECK_EN
        dest_err = valid_rx && (data_rx[4] != src_rx);
`else
        dest_err = 1'b0;
`endif
        state_nx = init ? INIT :
                   state == INIT ? IDLE :
                   (state == ERROR || pop_err || dest_err) ? ERROR :
                   state == IDLE ? (req ? ACTIVE : IDLE) :
                   (empty_D0 && empty_D1 && !valid_rx) ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= INIT;
            rr        <= 1'b0;
            valid_rx  <= 1'b0;
            src_rx    <= 1'b0;
            data_q    <= '0;
            cnt_D0    <= '0;
            cnt_D1    <= '0;
            idle_rx   <= 1'b0;
            active_rx <= 1'b0;
            error_rx  <= 1'b0;
        end else if (init) begin
            state     <= INIT;
            rr        <= 1'b0;
            valid_rx  <= 1'b0;
            src_rx    <= 1'b0;
            data_q    <= '0;
            cnt_D0    <= '0;
            cnt_D1    <= '0;
            idle_rx   <= 1'b0;
            active_rx <= 1'b0;
            error_rx  <= 1'b0;
        end else begin
            state     <= state_nx;
            idle_rx   <= state_nx == IDLE;
            active_rx <= state_nx == ACTIVE;
            error_rx  <= state_nx == ERROR;
            valid_rx  <= pop_D0 || pop_D1;
            if (pop_D0 || pop_D1) begin
                src_rx <= pop_D1;
                rr     <= pop_D0;
            end
            if (valid_rx)
                data_q <= data_rx;
            if (valid_rx && state != ERROR) begin
                if (src_rx)
                    cnt_D1 <= cnt_D1 + CNT_W'(1);
                else
                    cnt_D0 <= cnt_D0 + CNT_W'(1);
            end
        end
    end
endmodule
